vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameters H_ACTIVE default 640 (visible pixels per line), V_ACTIVE default 480 (visible lines) and FIFO_DEPTH default 4 (write-queue entries, power of two).
REQ-002 The block SHALL have port `pclk`, input, 1 bit: the single clock, 25 MHz pixel clock; all logic on its rising edge.
REQ-003 The block SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports `h_addr` and `v_addr`, inputs, 10 bits each: current scan pixel coordinate from the VGA timing controller.
REQ-005 The block SHALL have port `valid`, input, 1 bit: the VGA timing controller's active-video (not blanking) flag.
REQ-006 The block SHALL have port `wr_req`, input, 1 bit: the writer offers a pixel write.
REQ-007 The block SHALL have ports `wr_x` and `wr_y`, inputs, 10 bits each: write coordinate.
REQ-008 The block SHALL have port `wr_data`, input, 12 bits: RGB444 pixel.
REQ-009 The block SHALL have port `wr_ready`, output, 1 bit: the queue can accept a write this cycle.
REQ-010 The block SHALL have port `wr_drop`, output, 1 bit: sticky flag set when an out-of-range write is discarded.
REQ-011 The block SHALL have port `pending`, output, 3 bits: queue occupancy, 0..FIFO_DEPTH.
REQ-012 The block SHALL have port `mem_addr`, output, 19 bits: single-port video RAM address.
REQ-013 The block SHALL have port `mem_we`, output, 1 bit: RAM write enable.
REQ-014 The block SHALL have port `mem_wdata`, output, 12 bits: RAM write data.
REQ-015 The block SHALL have port `mem_rdata`, input, 12 bits: RAM read data, valid one cycle after the address is presented.
REQ-016 The block SHALL have port `vga_data`, output, 24 bits: colour delivered to the VGA timing controller.

Function
REQ-017 The address mapping SHALL be addr = y*640 + x, computed as (y<<9)+(y<<7)+x, zero-extended to 19 bits with no overflow for in-range coordinates.
REQ-018 A write SHALL be accepted on a cycle with wr_req=1 and wr_ready=1.
  - Accepted writes with wr_x<H_ACTIVE and wr_y<V_ACTIVE are enqueued as {addr, data}.
  - Accepted writes with either coordinate out of range are discarded; wr_drop is set the next cycle and held until reset.
REQ-019 wr_ready SHALL be registered and equal (pending<FIFO_DEPTH) as evaluated after the current cycle's enqueue/dequeue; it never depends combinationally on wr_req.
REQ-020 The FSM SHALL have states IDLE, DISP and DRAIN, evaluated each cycle with priority:
  - valid=1 -> DISP;
  - else pending>0 -> DRAIN;
  - else IDLE.
REQ-021 In DISP, the outputs SHALL be mem_we=0 and mem_addr=map(h_addr, v_addr); the display always wins and writes never occur during active video.
REQ-022 In DRAIN, the block SHALL present the queue head with mem_we=1 and pop one entry per cycle; back-to-back drains are allowed.
REQ-023 In IDLE, the outputs SHALL be mem_we=0 and mem_addr=0.
REQ-024 When valid rises while entries remain, draining SHALL stop that same cycle with no entry lost or duplicated, and resume at the next blanking.
REQ-025 When an enqueue and a dequeue occur in the same cycle, pending SHALL be unchanged and FIFO order SHALL be preserved.
REQ-026 Display path latency SHALL be 2 cycles.
  - valid is delayed 2 stages to give valid_d2.
  - mem_rdata is registered once.
  - vga_data = {r,r,g,g,b,b} nibble-replicated from the registered RGB444 when valid_d2=1, else 24'h0.
REQ-027 Queue pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL set:
  - state to IDLE and queue pointers and pending to 0;
  - wr_ready=0, wr_drop=0, mem_we=0, mem_addr=0, vga_data=0;
  - both valid delay stages to 0.
REQ-029 On the first cycle after reset deasserts, wr_ready SHALL be 1.
REQ-030 A reset asserted mid-drain SHALL discard all queued entries, and mem_we SHALL be 0 from the next edge.

Verification
REQ-031 Blanking write: valid=0, write (x=3,y=2,data=12'hF0A) -> within 2 cycles mem_we=1, mem_addr=1283, mem_wdata=12'hF0A.
REQ-032 Fill during active: valid=1, 5 back-to-back wr_req -> 4 accepted, wr_ready=0 after the 4th, pending=4, mem_we stays 0; when valid falls, 4 consecutive writes drain in order.
REQ-033 Display read: valid=1, h=639, v=479, mem_rdata=12'h5C3 next cycle -> mem_addr=307199, and vga_data=24'h55CC33 two cycles later.
REQ-034 Out-of-range write: write x=640,y=0 -> wr_drop=1 next cycle, pending stays 0, no mem_we.
REQ-035 Preemption: 3 entries queued, valid rises after 1 drain -> pending=2, mem_we=0 while valid=1, 2 drains follow at the next blanking.
REQ-036 Reset mid-drain: reset during DRAIN -> pending=0, mem_we=0, vga_data=0; wr_ready=1 on the first cycle after reset deasserts.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: the scan-out read path owns the RAM during
// active video; queued pixel writes drain during blanking.
module vram_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        valid,
  input  logic        wr_req,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic [11:0] wr_data,
  output logic        wr_ready,
  output logic        wr_drop,
  output logic [2:0]  pending,
  output logic [18:0] mem_addr,
  output logic        mem_we,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata,
  output logic [23:0] vga_data,
  output logic [1:0]  fsm_state
);

  // Write handshake: a write transfers on any cycle where wr_req and wr_ready
  // are both high; wr_ready is registered and never looks at wr_req.

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [9:0]    H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0]    V_LIM = 10'(V_ACTIVE);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DISP  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_q;

  logic [30:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          accept;
  logic          in_range;
  logic          push;
  logic          pop;
  logic          valid_d1;
  logic          valid_d2;
  logic [11:0]   rgb_q;

  function automatic logic [18:0] map_addr(input logic [9:0] x, input logic [9:0] y);
    return ({9'd0, y} << 9) + ({9'd0, y} << 7) + {9'd0, x};
  endfunction

  assign accept     = wr_req & wr_ready;
  assign in_range   = (wr_x < H_LIM) && (wr_y < V_LIM);
  assign push       = accept & in_range;
  assign count_next = count + CW'(push) - CW'(pop);

  // The mode is chosen from this cycle's inputs so that the display takes the
  // RAM on the very cycle valid rises; state_q records it for observation.
  always_comb begin
    state     = IDLE;
    mem_we    = 1'b0;
    mem_addr  = 19'd0;
    mem_wdata = 12'd0;
    pop       = 1'b0;
    if (reset)           state = IDLE;
    else if (valid)      state = DISP;
    else if (count != 0) state = DRAIN;
    case (state)
      DISP:  mem_addr = map_addr(h_addr, v_addr);
      DRAIN: begin
        mem_we                = 1'b1;
        {mem_addr, mem_wdata} = fifo[rd_ptr];
        pop                   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (push) fifo[wr_ptr] <= {map_addr(wr_x, wr_y), wr_data};
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wr_ready <= 1'b0;
      wr_drop  <= 1'b0;
      valid_d1 <= 1'b0;
      valid_d2 <= 1'b0;
      rgb_q    <= 12'd0;
    end else begin
      state_q  <= state;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count    <= count_next;
      wr_ready <= (count_next < DEPTH);
      if (accept && !in_range) wr_drop <= 1'b1;
      valid_d1 <= valid;
      valid_d2 <= valid_d1;
      rgb_q    <= mem_rdata;
    end
  end

  assign pending   = 3'(count);
  assign fsm_state = state_q;
  assign vga_data  = valid_d2 ? {rgb_q[11:8], rgb_q[11:8], rgb_q[7:4], rgb_q[7:4],
                                 rgb_q[3:0], rgb_q[3:0]} : 24'h0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_vram_arbiter;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  h_addr = '0;
  logic [9:0]  v_addr = '0;
  logic        valid = 1'b0;
  logic        wr_req = 1'b0;
  logic [9:0]  wr_x = '0;
  logic [9:0]  wr_y = '0;
  logic [11:0] wr_data = '0;
  logic [11:0] mem_rdata = '0;
  logic        wr_ready;
  logic        wr_drop;
  logic [2:0]  pending;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [23:0] vga_data;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;

  vram_arbiter dut (
    .pclk(pclk), .reset(reset), .h_addr(h_addr), .v_addr(v_addr), .valid(valid),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_drop(wr_drop), .pending(pending),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .vga_data(vga_data), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // reference model: queue of {addr, data}, plus registered flags and pipeline
  logic [30:0] exp_q[$];
  logic        m_ready = 1'b0;
  logic        m_drop  = 1'b0;
  logic        m_vd1   = 1'b0;
  logic        m_vd2   = 1'b0;
  logic [11:0] m_rgb   = '0;

  always @(posedge pclk) begin
    if (reset) begin
      exp_q.delete();
      m_ready = 1'b0;
      m_drop  = 1'b0;
      m_vd1   = 1'b0;
      m_vd2   = 1'b0;
      m_rgb   = '0;
    end else begin
      if (!valid && exp_q.size() > 0) void'(exp_q.pop_front());
      if (wr_req && m_ready) begin
        if (int'(wr_x) < 640 && int'(wr_y) < 480)
          exp_q.push_back({19'(int'(wr_y) * 640 + int'(wr_x)), wr_data});
        else
          m_drop = 1'b1;
      end
      m_ready = (exp_q.size() < 4);
      m_vd2   = m_vd1;
      m_vd1   = valid;
      m_rgb   = mem_rdata;
    end
  end

  // scoreboard compare, every cycle on the falling edge
  logic        e_we;
  logic [18:0] e_addr;
  logic [11:0] e_data;
  logic [23:0] e_vga;

  always @(negedge pclk) begin
    e_we   = !reset && !valid && exp_q.size() > 0;
    e_addr = '0;
    e_data = '0;
    if (!reset && valid) e_addr = 19'(int'(v_addr) * 640 + int'(h_addr));
    else if (e_we) {e_addr, e_data} = exp_q[0];
    e_vga = m_vd2 ? {8'(m_rgb[11:8] * 17), 8'(m_rgb[7:4] * 17), 8'(m_rgb[3:0] * 17)} : 24'h0;
    check("cyc_wr_ready", 32'(wr_ready), 32'(m_ready));
    check("cyc_wr_drop", 32'(wr_drop), 32'(m_drop));
    check("cyc_pending", 32'(pending), 32'(exp_q.size()));
    check("cyc_mem_we", 32'(mem_we), 32'(e_we));
    check("cyc_mem_addr", 32'(mem_addr), 32'(e_addr));
    check("cyc_mem_wdata", 32'(mem_wdata), 32'(e_data));
    check("cyc_vga_data", 32'(vga_data), 32'(e_vga));
  end

  // driver tasks
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic wr_one(input int x, input int y, input logic [11:0] d);
    wr_req  = 1'b1;
    wr_x    = 10'(x);
    wr_y    = 10'(y);
    wr_data = d;
    tick();
    wr_req  = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_vga", 32'(vga_data), 0);
    check("rst_drop", 32'(wr_drop), 0);
    reset = 1'b0;
    tick();
    check("ready_after_rst", 32'(wr_ready), 1);

    // blanking write
    wr_one(3, 2, 12'hF0A);
    #1;
    check("blank_we", 32'(mem_we), 1);
    check("blank_addr", 32'(mem_addr), 1283);
    check("blank_data", 32'(mem_wdata), 32'h0F0A);
    tick();
    #1;
    check("blank_done_we", 32'(mem_we), 0);

    // out-of-range write
    wr_one(640, 0, 12'h123);
    #1;
    check("oor_drop", 32'(wr_drop), 1);
    check("oor_pending", 32'(pending), 0);
    check("oor_we", 32'(mem_we), 0);
    tick();

    // fill during active video
    valid  = 1'b1;
    h_addr = 10'd10;
    v_addr = 10'd20;
    for (int i = 0; i < 5; i++) begin
      wr_req  = 1'b1;
      wr_x    = 10'(i);
      wr_y    = 10'd1;
      wr_data = 12'h100 + 12'(i);
      tick();
      if (i == 3) begin
        #1;
        check("fill_ready", 32'(wr_ready), 0);
        check("fill_pending", 32'(pending), 4);
      end
    end
    wr_req = 1'b0;
    #1;
    check("fill_pending5", 32'(pending), 4);
    check("fill_we", 32'(mem_we), 0);
    check("fill_disp_addr", 32'(mem_addr), 12810);
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_we", 32'(mem_we), 1);
      check("drain_addr", 32'(mem_addr), 32'(640 + i));
      check("drain_data", 32'(mem_wdata), 32'(12'h100 + 12'(i)));
      tick();
    end
    #1;
    check("drain_empty", 32'(pending), 0);

    // display read at the last pixel
    valid  = 1'b1;
    h_addr = 10'd639;
    v_addr = 10'd479;
    #1;
    check("disp_addr", 32'(mem_addr), 307199);
    tick();
    mem_rdata = 12'h5C3;
    valid     = 1'b0;
    tick();
    #1;
    check("disp_vga", 32'(vga_data), 32'h55CC33);
    tick();
    #1;
    check("disp_vga_off", 32'(vga_data), 0);

    // preemption of a drain by active video
    valid  = 1'b1;
    h_addr = 10'd5;
    v_addr = 10'd5;
    for (int i = 0; i < 3; i++) wr_one(100 + i, 200, 12'hA00 + 12'(i));
    valid = 1'b0;
    #1;
    check("pre_first_addr", 32'(mem_addr), 128100);
    tick();
    valid = 1'b1;
    #1;
    check("pre_we_off", 32'(mem_we), 0);
    check("pre_pending", 32'(pending), 2);
    repeat (3) tick();
    valid = 1'b0;
    #1;
    check("pre_resume1", 32'(mem_addr), 128101);
    tick();
    #1;
    check("pre_resume2", 32'(mem_addr), 128102);
    tick();
    #1;
    check("pre_empty", 32'(pending), 0);

    // reset during a drain
    valid = 1'b1;
    for (int i = 0; i < 3; i++) wr_one(7 + i, 9, 12'h3C0 + 12'(i));
    valid = 1'b0;
    tick();
    #1;
    check("mid_pending", 32'(pending), 2);
    check("mid_we", 32'(mem_we), 1);
    reset = 1'b1;
    tick();
    #1;
    check("mid_rst_pending", 32'(pending), 0);
    check("mid_rst_we", 32'(mem_we), 0);
    check("mid_rst_vga", 32'(vga_data), 0);
    check("mid_rst_ready", 32'(wr_ready), 0);
    check("mid_rst_drop", 32'(wr_drop), 0);
    reset = 1'b0;
    tick();
    #1;
    check("mid_ready_after", 32'(wr_ready), 1);
    check("mid_after_we", 32'(mem_we), 0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
